// File: rtl/mem_map_pkg.sv
// Address map and I/O register layout shared by the CPU-side bridge.
package mem_map_pkg;

    // Memory-mapped I/O window (RAM window size comes from RAM_ADDR_W)
    localparam logic [15:0] IO_BASE  = 16'hFF00;
    localparam logic [15:0] IO_LIMIT = 16'hFF0F;

    // I/O register offsets within the window
    localparam logic [3:0] IO_LED    = 4'h0;
    localparam logic [3:0] IO_TXDATA = 4'h1;
    localparam logic [3:0] IO_STATUS = 4'h2;
    localparam logic [3:0] IO_TIMER  = 4'h3;

    // STATUS register bit positions
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_CNT_LSB = 2;
    localparam int ST_CNT_MSB = 4;
    localparam int ST_OVF     = 5;

endpackage

// File: rtl/io_tx_fifo.sv
// Byte FIFO feeding the TX valid/ready stream. A push while full is accepted
// only when a pop frees the head in the same cycle; otherwise it is dropped
// and flagged through overflow_event.
module io_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             overflow_event
);

    logic [7:0]       store [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             do_push;

    // Accept/drop decisions for this cycle
    always_comb begin
        empty          = (count == '0);
        full           = (count == CNT_W'(FIFO_DEPTH));
        do_pop         = pop && !empty;
        do_push        = push && (!full || do_pop);
        overflow_event = push && full && !do_pop;
        head           = empty ? 8'h00 : store[rd_ptr];
    end

    // Pointers and occupancy; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Entry storage needs no reset; head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/memory_io_bridge.sv
// Splits CPU memory strobes between external RAM, a small I/O register block
// and unmapped space, returning read data with the same latency for all.
module memory_io_bridge
    import mem_map_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RAM_ADDR_W = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cpu_addr,
    input  logic [15:0]           cpu_wdata,
    input  logic                  cpu_read_en,
    input  logic                  cpu_write_en,
    output logic [15:0]           cpu_rdata,
    output logic [RAM_ADDR_W-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [15:0]           mem_rdata,
    output logic [7:0]            led_out,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             is_ram;
    logic             is_io;
    logic             is_read;
    logic             is_write;
    logic [3:0]       io_off;
    logic [31:0]      addr_ext;
    logic [15:0]      rd_mux;
    logic [15:0]      status;
    logic [7:0]       cnt_ext;
    logic [2:0]       cnt_field;
    logic             push;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow_event;

    logic [15:0]      timer;
    logic             ovf;
    logic             pending_ram;
    logic             pending_io;
    logic [15:0]      io_hold;

    // Address decode and RAM strobes; a write always wins over a read
    always_comb begin
        addr_ext  = {16'h0000, cpu_addr};
        is_ram    = ((addr_ext >> RAM_ADDR_W) == 32'd0);
        is_io     = !is_ram && (cpu_addr >= IO_BASE) && (cpu_addr <= IO_LIMIT);
        io_off    = cpu_addr[3:0];
        is_write  = cpu_write_en;
        is_read   = cpu_read_en && !cpu_write_en;
        mem_addr  = cpu_addr[RAM_ADDR_W-1:0];
        mem_wdata = cpu_wdata;
        mem_we    = !rst && is_write && is_ram;
        mem_re    = !rst && is_read && is_ram;
        push      = is_write && is_io && (io_off == IO_TXDATA);
    end

    // STATUS word and I/O read mux (unmapped space reads zero)
    always_comb begin
        cnt_ext   = 8'(fifo_count);
        cnt_field = (cnt_ext > 8'd7) ? 3'd7 : cnt_ext[2:0];
        status    = '0;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_FULL]               = fifo_full;
        status[ST_CNT_MSB:ST_CNT_LSB] = cnt_field;
        status[ST_OVF]                = ovf;
        rd_mux = 16'h0000;
        if (is_io) begin
            case (io_off)
                IO_LED:    rd_mux = {8'h00, led_out};
                IO_STATUS: rd_mux = status;
                IO_TIMER:  rd_mux = timer;
                default:   rd_mux = 16'h0000;
            endcase
        end
    end

    // I/O registers, sticky overflow flag and free-running timer
    always_ff @(posedge clk) begin
        if (rst) begin
            led_out <= '0;
            timer   <= '0;
            ovf     <= 1'b0;
        end else begin
            if (is_write && is_io && io_off == IO_LED) led_out <= cpu_wdata[7:0];
            if (is_write && is_io && io_off == IO_TIMER) timer <= cpu_wdata;
            else                                         timer <= timer + 16'd1;
            // A fresh overflow beats a simultaneous clear
            if (overflow_event)                                 ovf <= 1'b1;
            else if (is_write && is_io && io_off == IO_STATUS) ovf <= 1'b0;
        end
    end

    // Read pipeline: RAM data arrives a cycle late, so I/O data is held one
    // extra stage to give both the same latency
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_ram <= 1'b0;
            pending_io  <= 1'b0;
            io_hold     <= '0;
            cpu_rdata   <= '0;
        end else begin
            pending_ram <= is_read && is_ram;
            pending_io  <= is_read && !is_ram;
            io_hold     <= rd_mux;
            if (pending_ram)     cpu_rdata <= mem_rdata;
            else if (pending_io) cpu_rdata <= io_hold;
        end
    end

    io_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .push_data      (cpu_wdata[7:0]),
        .pop            (tx_ready),
        .head           (tx_data),
        .empty          (fifo_empty),
        .full           (fifo_full),
        .count          (fifo_count),
        .overflow_event (overflow_event)
    );

    assign tx_valid = !fifo_empty;

endmodule

// File: tb/tb_memory_io_bridge.sv
// Directed bench for memory_io_bridge with a simple one-cycle-latency RAM model.
module tb_memory_io_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_read_en;
    logic        cpu_write_en;
    logic [15:0] cpu_rdata;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [7:0]  led_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] ram [256];
    logic [15:0] rd;

    memory_io_bridge #(.FIFO_DEPTH(4), .RAM_ADDR_W(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_read_en  (cpu_read_en),
        .cpu_write_en (cpu_write_en),
        .cpu_rdata    (cpu_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .led_out      (led_out),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    // External RAM model: data valid the cycle after mem_re
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
        cpu_addr     = addr;
        cpu_wdata    = data;
        cpu_write_en = 1'b1;
        cpu_read_en  = 1'b0;
        tick();
        cpu_write_en = 1'b0;
    endtask

    // Request cycle, then one more edge for the result to land
    task automatic cpu_read(input logic [15:0] addr, output logic [15:0] data);
        cpu_addr    = addr;
        cpu_read_en = 1'b1;
        tick();
        cpu_read_en = 1'b0;
        tick();
        data = cpu_rdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_bytes [4];
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        mem_rdata    = 16'h0000;
        rst          = 1'b1;
        cpu_addr     = 16'h0010;
        cpu_wdata    = 16'h1234;
        cpu_read_en  = 1'b0;
        cpu_write_en = 1'b1;
        tx_ready     = 1'b0;
        #1;
        chk("rst_mem_we_forced", {15'd0, mem_we}, 16'd0);
        tick(); tick(); tick();
        cpu_write_en = 1'b0;
        rst = 1'b0;
        chk("rst_rdata", cpu_rdata, 16'h0000);
        chk("rst_led", {8'd0, led_out}, 16'h0000);
        chk("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
        chk("rst_tx_data", {8'd0, tx_data}, 16'h0000);

        // 1: RAM write and read latency
        cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF; cpu_write_en = 1'b1;
        #1;
        chk("ram_wr_we", {15'd0, mem_we}, 16'd1);
        chk("ram_wr_addr", {1'b0, mem_addr}, 16'h0010);
        chk("ram_wr_data", mem_wdata, 16'hBEEF);
        chk("ram_wr_re", {15'd0, mem_re}, 16'd0);
        tick();
        cpu_write_en = 1'b0;
        cpu_read_en = 1'b1;
        #1;
        chk("ram_rd_re", {15'd0, mem_re}, 16'd1);
        tick();
        cpu_read_en = 1'b0;
        chk("ram_rd_not_yet", cpu_rdata, 16'h0000);
        tick();
        chk("ram_rd_data", cpu_rdata, 16'hBEEF);
        tick(); tick();
        chk("ram_rd_hold", cpu_rdata, 16'hBEEF);

        // 2: LED and unmapped
        cpu_write(16'hFF00, 16'h00A5);
        chk("led_out", {8'd0, led_out}, 16'h00A5);
        cpu_read(16'hFF00, rd);
        chk("led_read", rd, 16'h00A5);
        cpu_addr = 16'h9000; cpu_read_en = 1'b1;
        #1;
        chk("unmap_rd_re", {15'd0, mem_re}, 16'd0);
        tick();
        cpu_read_en = 1'b0;
        tick();
        chk("unmap_rd_data", cpu_rdata, 16'h0000);
        cpu_addr = 16'h9000; cpu_wdata = 16'h7777; cpu_write_en = 1'b1;
        #1;
        chk("unmap_wr_we", {15'd0, mem_we}, 16'd0);
        tick();
        cpu_write_en = 1'b0;

        // 3: overflow, drain, clear
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) cpu_write(16'hFF01, 16'(i * 16'h11));
        cpu_read(16'hFF02, rd);
        chk("status_ovf_full", rd, 16'h0032);
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", {15'd0, tx_valid}, 16'd1);
            chk("drain_data", {8'd0, tx_data}, {8'd0, exp_bytes[i]});
            tick();
        end
        chk("drain_empty", {15'd0, tx_valid}, 16'd0);
        tx_ready = 1'b0;
        cpu_write(16'hFF02, 16'h0000);
        cpu_read(16'hFF02, rd);
        chk("status_cleared", rd, 16'h0001);

        // 4: push while full with simultaneous pop
        for (int i = 1; i <= 4; i++) cpu_write(16'hFF01, 16'(i * 16'h11));
        cpu_addr = 16'hFF01; cpu_wdata = 16'h0066; cpu_write_en = 1'b1; tx_ready = 1'b1;
        tick();
        cpu_write_en = 1'b0; tx_ready = 1'b0;
        cpu_read(16'hFF02, rd);
        chk("status_full_nopov", rd, 16'h0012);
        exp_bytes = '{8'h22, 8'h33, 8'h44, 8'h66};
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pushpop_data", {8'd0, tx_data}, {8'd0, exp_bytes[i]});
            tick();
        end
        chk("pushpop_empty", {15'd0, tx_valid}, 16'd0);
        tx_ready = 1'b0;

        // 5: timer load, wrap, reload
        cpu_write(16'hFF03, 16'hFFFE);
        cpu_read(16'hFF03, rd);
        chk("timer_load", rd, 16'hFFFE);
        cpu_read(16'hFF03, rd);
        chk("timer_wrap", rd, 16'h0000);
        cpu_read(16'hFF03, rd);
        chk("timer_after_wrap", rd, 16'h0002);
        cpu_write(16'hFF03, 16'h1234);
        cpu_read(16'hFF03, rd);
        chk("timer_reload", rd, 16'h1234);

        // 6: write wins over read; reset mid-transfer
        cpu_addr = 16'h0020; cpu_wdata = 16'h5A5A; cpu_write_en = 1'b1; cpu_read_en = 1'b1;
        #1;
        chk("rw_we", {15'd0, mem_we}, 16'd1);
        chk("rw_re", {15'd0, mem_re}, 16'd0);
        tick();
        cpu_write_en = 1'b0; cpu_read_en = 1'b0;
        tick();
        chk("rw_rdata_held", cpu_rdata, 16'h1234);
        cpu_read(16'h0020, rd);
        chk("rw_ram_written", rd, 16'h5A5A);
        for (int i = 1; i <= 3; i++) cpu_write(16'hFF01, 16'(i));
        cpu_write(16'hFF00, 16'h003C);
        chk("pre_rst_valid", {15'd0, tx_valid}, 16'd1);
        cpu_addr = 16'h0020; cpu_read_en = 1'b1;
        tick();
        cpu_read_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {15'd0, tx_valid}, 16'd0);
        chk("mid_rst_data", {8'd0, tx_data}, 16'h0000);
        chk("mid_rst_led", {8'd0, led_out}, 16'h0000);
        chk("mid_rst_rdata", cpu_rdata, 16'h0000);
        tick();
        chk("mid_rst_no_pending", cpu_rdata, 16'h0000);
        cpu_read(16'hFF02, rd);
        chk("mid_rst_status", rd, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_io_bridge.md
Name: memory_io_bridge

Overview:
- Sits directly downstream of the CPU control unit's single-port memory strobes (address, write data, read enable, write enable, read data).
- Decodes each access to one of three targets: external synchronous RAM, a small block of memory-mapped I/O registers, or unmapped space.
- I/O targets:
  - LED register
  - free-running cycle timer
  - byte TX FIFO with a valid/ready output stream
- Gives the CPU one uniform read latency regardless of target.

Parameters:
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16
RAM_ADDR_W, 15, external RAM word-address width; RAM occupies 0x0000..(2^RAM_ADDR_W - 1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
cpu_addr  in  16  CPU word address
cpu_wdata  in  16  CPU write data
cpu_read_en  in  1  CPU read strobe, one access per cycle it is high
cpu_write_en  in  1  CPU write strobe
cpu_rdata  out  16  read data returned to CPU, registered/held
mem_addr  out  RAM_ADDR_W  external RAM address
mem_wdata  out  16  external RAM write data
mem_re  out  1  external RAM read enable
mem_we  out  1  external RAM write enable
mem_rdata  in  16  external RAM read data, valid the cycle after mem_re
led_out  out  8  LED register
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  downstream consumer accepts head when tx_valid && tx_ready

Behaviour:
- Reset (rst high at a clock edge):
  - cpu_rdata=0, led_out=0, timer=0, FIFO emptied (tx_valid=0, tx_data=0), overflow flag=0, pending-read state cleared.
  - mem_re/mem_we are combinational but forced 0 while rst is high.
  - Reset mid-transfer discards FIFO contents and any pending read.
- Address map (constants in package):
  - RAM = addr < 2^RAM_ADDR_W
  - IO = 0xFF00..0xFF0F
  - everything else unmapped
- IO registers:
  - 0xFF00 LED: RW, bits[7:0]; reads return {8'h00, led}.
  - 0xFF01 TXDATA: a write pushes cpu_wdata[7:0]; reads return 0.
  - 0xFF02 STATUS: read = {10'b0, ovf, count[2:0], full, empty}; count saturates at 7 in the field. Any write clears ovf.
  - 0xFF03 TIMER: RW, 16-bit. Increments every cycle and wraps 0xFFFF->0x0000. A write loads cpu_wdata and there is no increment that cycle.
  - 0xFF04..0xFF0F: read 0, writes ignored.
- Strobes:
  - If cpu_write_en is high, the access is a write and cpu_read_en is ignored that cycle.
  - RAM write: mem_we=1, mem_addr=cpu_addr[RAM_ADDR_W-1:0], mem_wdata=cpu_wdata, same cycle (combinational). IO writes take effect at that edge.
  - RAM read: mem_re=1 in the request cycle. A 1-bit pending_ram flag is registered.
  - Next cycle: cpu_rdata <= mem_rdata when pending_ram. For IO/unmapped reads, the IO value (or 0) is captured at the request edge and presented the following cycle.
  - Net effect: cpu_rdata updates exactly one cycle after the request edge for all targets, and holds until the next read completes.
  - Unmapped accesses never assert mem_re/mem_we.
  - Timer read returns its value at the request edge.
- FIFO:
  - tx_valid = !empty; tx_data = head entry.
  - Pop on tx_valid && tx_ready.
  - Push when not full.
  - Push when full with simultaneous pop: accepted, count unchanged.
  - Push when full without pop: byte dropped, ovf set (sticky).
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH; count is clog2(FIFO_DEPTH)+1 bits.
  - If an ovf-clearing write and a new overflow land in the same cycle, the overflow wins (ovf=1).

Decomposition:
- Package mem_map_pkg holds:
  - RAM/IO base and limit constants
  - IO offsets (LED=0, TXDATA=1, STATUS=2, TIMER=3)
  - STATUS bit indices
- Sub-module io_tx_fifo(clk, rst, push, push_data, pop, head, empty, full, count, overflow_event) parameterised by FIFO_DEPTH.
- Address decode, registers, timer and read mux stay in memory_io_bridge.

Test Plan:
1. Reset release, write 0xBEEF to 0x0010 -> mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF same cycle; read 0x0010 with model returning 0xBEEF -> mem_re=1, cpu_rdata=0xBEEF exactly one cycle later, held until next read.
2. Write 0x00A5 to 0xFF00 -> led_out=0xA5 next cycle; read 0xFF00 -> cpu_rdata=0x00A5; read 0x9000 -> cpu_rdata=0x0000, mem_re/mem_we never asserted.
3. tx_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> STATUS reads full=1, count=4, ovf=1. Then tx_ready=1 -> tx_data sequence 0x11,0x22,0x33,0x44, then tx_valid=0; write STATUS -> ovf=0.
4. FIFO full, push 0x66 in the same cycle tx_ready=1 pops 0x11 -> count stays 4, ovf stays 0, 0x66 emerges last.
5. Write 0xFFFE to 0xFF03 -> timer reads 0xFFFE+k on subsequent reads; wraps through 0x0000. Write during count loads exactly the written value.
6. Simultaneous cpu_read_en and cpu_write_en to 0x0020 -> only mem_we asserted, cpu_rdata unchanged. Assert rst while FIFO holds 3 bytes -> tx_valid=0, led_out=0, cpu_rdata=0 after that edge.
